// File: rtl/rf_issue_pkg.sv
// Shared types and constants for the register-fetch issue scoreboard.
// Consumers: rf_pend_counters, rf_issue_scoreboard.
package rf_issue_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_HAZ = 2'd1,
        WAIT_RDY = 2'd2
    } issue_state_e;

    // Payload is kept in a separate register so PAYLOAD_W stays a top-level parameter.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_used;
        logic       rs2_used;
        logic       regw;
    } issue_bundle_t;

    function automatic int unsigned pend_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/rf_pend_counters.sv
// Per-register outstanding-write counters with busy/full views and sticky underflow.
// SCOREBOARD_BYPASS_EN: busy/full views subtract a same-cycle writeback.
module rf_pend_counters
    import rf_issue_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int PEND_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_inc_en,
    input  logic [$clog2(NREG)-1:0] i_inc_idx,
    input  logic                    i_dec_en,
    input  logic [$clog2(NREG)-1:0] i_dec_idx,
    output logic [NREG-1:0]         o_busy,
    output logic [NREG-1:0]         o_full,
    output logic                    o_underflow
);

    localparam int IDX_W = $clog2(NREG);
    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

    logic [PEND_W-1:0] r_pend [NREG];
    logic              r_underflow;
    logic [NREG-1:0]   w_inc_hit;
    logic [NREG-1:0]   w_dec_hit;
    logic [PEND_W-1:0] w_eff [NREG];
    logic              w_underflow;

    always_comb begin
        w_inc_hit   = '0;
        w_dec_hit   = '0;
        w_underflow = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            w_inc_hit[i] = i_inc_en && (i_inc_idx == IDX_W'(i));
            w_dec_hit[i] = i_dec_en && (i_dec_idx == IDX_W'(i));
            if (w_dec_hit[i] && !w_inc_hit[i] && (r_pend[i] == '0))
                w_underflow = 1'b1;
        end
    end

    always_comb begin
        o_busy = '0;
        o_full = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_eff[i] = r_pend[i];
`ifdef SCOREBOARD_BYPASS_EN
            if (w_dec_hit[i] && (r_pend[i] != '0))
                w_eff[i] = r_pend[i] - 1'b1;
`endif
            o_busy[i] = (w_eff[i] != '0);
            o_full[i] = (w_eff[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_pend[i] <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (w_inc_hit[i] && !w_dec_hit[i])
                    r_pend[i] <= r_pend[i] + 1'b1;
                else if (w_dec_hit[i] && !w_inc_hit[i] && (r_pend[i] != '0))
                    r_pend[i] <= r_pend[i] - 1'b1;
            end
            if (w_underflow)
                r_underflow <= 1'b1;
        end
    end

    assign o_underflow = r_underflow;

endmodule

// File: rtl/rf_issue_scoreboard.sv
// Register-fetch holding stage: scoreboard hazard check and valid/ready issue to execute.
// SCOREBOARD_BYPASS_EN (in rf_pend_counters): same-cycle writeback clears a RAW hazard.
module rf_issue_scoreboard
    import rf_issue_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int PEND_W    = 2,
    parameter int PAYLOAD_W = 64+64+6+7+8+3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_rs1_used,
    input  logic                 in_rs2_used,
    input  logic                 in_regw,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 decode_enable,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [4:0]           issue_rs1,
    output logic [4:0]           issue_rs2,
    output logic [4:0]           issue_rd,
    output logic                 issue_regw,
    output logic [PAYLOAD_W-1:0] issue_payload,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic                 flush,
    output logic                 wb_err,
    output logic [31:0]          stall_cycles
);

    localparam int IDX_W = $clog2(NREG);

    issue_state_e          r_state;
    issue_state_e          w_state_nxt;
    issue_bundle_t         r_b;
    logic [PAYLOAD_W-1:0]  r_payload;
    logic [31:0]           r_stall;
    logic [NREG-1:0]       w_busy;
    logic [NREG-1:0]       w_full;
    logic                  w_hold;
    logic                  w_hazard;
    logic                  w_fire;
    logic                  w_accept;
    logic                  w_inc_en;
    logic                  w_dec_en;

    rf_pend_counters #(
        .NREG   (NREG),
        .PEND_W (PEND_W)
    ) u_pend (
        .clk         (clk),
        .rst         (rst),
        .i_inc_en    (w_inc_en),
        .i_inc_idx   (IDX_W'(r_b.rd)),
        .i_dec_en    (w_dec_en),
        .i_dec_idx   (IDX_W'(wb_rd)),
        .o_busy      (w_busy),
        .o_full      (w_full),
        .o_underflow (wb_err)
    );

    // State IDLE means empty; the WAIT_* split records why a held bundle did not leave.
    always_comb begin
        w_hold        = (r_state != IDLE);
        w_hazard      = (r_b.rs1_used && (r_b.rs1 != REG_ZERO) && w_busy[r_b.rs1]) ||
                        (r_b.rs2_used && (r_b.rs2 != REG_ZERO) && w_busy[r_b.rs2]) ||
                        (r_b.regw     && (r_b.rd  != REG_ZERO) && w_full[r_b.rd]);
        issue_valid   = w_hold && !w_hazard && !flush;
        w_fire        = issue_valid && issue_ready;
        decode_enable = !w_hold || w_fire || flush;
        w_accept      = in_valid && decode_enable;
        w_inc_en      = w_fire && r_b.regw && (r_b.rd != REG_ZERO);
        w_dec_en      = wb_valid && (wb_rd != REG_ZERO);

        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = WAIT_RDY;
        else if (w_fire || flush)
            w_state_nxt = IDLE;
        else if (w_hold)
            w_state_nxt = w_hazard ? WAIT_HAZ : WAIT_RDY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b       <= '0;
            r_payload <= '0;
        end else if (w_accept) begin
            r_b.rs1      <= in_rs1;
            r_b.rs2      <= in_rs2;
            r_b.rd       <= in_rd;
            r_b.rs1_used <= in_rs1_used;
            r_b.rs2_used <= in_rs2_used;
            r_b.regw     <= in_regw;
            r_payload    <= in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall <= '0;
        else if (w_hold && !w_fire && (r_stall != '1))
            r_stall <= r_stall + 32'd1;
    end

    assign issue_rs1     = r_b.rs1;
    assign issue_rs2     = r_b.rs2;
    assign issue_rd      = r_b.rd;
    assign issue_regw    = r_b.regw;
    assign issue_payload = r_payload;
    assign stall_cycles  = r_stall;

endmodule

// File: tb/tb_rf_issue_scoreboard.sv
// Directed table plus hand sequences for rf_issue_scoreboard.
// Expectations follow SCOREBOARD_BYPASS_EN when it is defined for the build.
module tb_rf_issue_scoreboard;

    localparam int PW = 64+64+6+7+8+3;
`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [4:0]    in_rs1, in_rs2, in_rd;
    logic          in_rs1_used, in_rs2_used, in_regw;
    logic [PW-1:0] in_payload;
    logic          decode_enable, issue_valid, issue_ready;
    logic [4:0]    issue_rs1, issue_rs2, issue_rd;
    logic          issue_regw;
    logic [PW-1:0] issue_payload;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          flush;
    logic          wb_err;
    logic [31:0]   stall_cycles;

    int total = 0;
    int bad   = 0;

    rf_issue_scoreboard #(.NREG(32), .PEND_W(2), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_regw(in_regw),
        .in_payload(in_payload), .decode_enable(decode_enable),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_regw(issue_regw), .issue_payload(issue_payload),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .wb_err(wb_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw;
        logic [7:0] tag;
        logic       rdy, wbv;
        logic [4:0] wbrd;
        logic       fl;
        logic       e_iv, e_de;
        logic [4:0] e_rd;
        logic [7:0] e_tag;
        logic       e_err;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, rs2, rd,
                                input logic u1, u2, rw, input logic [7:0] tag,
                                input logic rdy, wbv, input logic [4:0] wbrd, input logic fl,
                                input logic e_iv, e_de, input logic [4:0] e_rd,
                                input logic [7:0] e_tag, input logic e_err);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.u1 = u1; t.u2 = u2; t.rw = rw; t.tag = tag;
        t.rdy = rdy; t.wbv = wbv; t.wbrd = wbrd; t.fl = fl;
        t.e_iv = e_iv; t.e_de = e_de; t.e_rd = e_rd; t.e_tag = e_tag; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic setin(input logic v, input logic [4:0] rs1, rs2, rd,
                         input logic u1, u2, rw, input logic [7:0] tag);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_used = u1; in_rs2_used = u2; in_regw = rw;
        in_payload = PW'(tag);
    endtask

    task automatic setctl(input logic rdy, wbv, input logic [4:0] wbrd, input logic fl);
        issue_ready = rdy; wb_valid = wbv; wb_rd = wbrd; flush = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        setin(0, 0, 0, 0, 0, 0, 0, 8'h00);
        setctl(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
    endtask

    initial begin
        vt[0] = mk(1, 1, 2, 3, 1, 1, 1, 8'hA1,  1, 0, 0, 0,  0, 1, 0,  8'h00, 0);
        vt[1] = mk(1, 6, 0, 0, 1, 1, 1, 8'hB2,  1, 0, 0, 0,  1, 1, 3,  8'hA1, 0);
        vt[2] = mk(1, 0, 0, 8, 1, 1, 1, 8'hC3,  0, 0, 0, 0,  1, 0, 0,  8'hB2, 0);
        vt[3] = mk(1, 0, 0, 8, 1, 1, 1, 8'hC3,  1, 0, 0, 0,  1, 1, 0,  8'hB2, 0);
        vt[4] = mk(1, 3, 0, 9, 1, 0, 1, 8'hD4,  1, 0, 0, 0,  1, 1, 8,  8'hC3, 0);
        vt[5] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 0,  0, 0, 9,  8'hD4, 0);
        vt[6] = mk(1, 1, 0, 10, 1, 0, 1, 8'hE5, 1, 1, 8, 1,  0, 1, 9,  8'hD4, 0);
        vt[7] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 9, 0,  1, 1, 10, 8'hE5, 0);
        vt[8] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 0,  0, 1, 10, 8'hE5, 1);
        vt[9] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00,  1, 1, 0, 0,  0, 1, 10, 8'hE5, 1);

        // reset values
        do_reset;
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_decode_enable", decode_enable, 1'b1);
        chk("rst_wb_err", wb_err, 1'b0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_issue_rd", issue_rd, 5'd0);
        chk("rst_payload", issue_payload[31:0], 32'd0);

        // table: pipeline, rd=0, ready stall, hazard, flush with accept, wb underflow
        for (int i = 0; i < 10; i++) begin
            setin(vt[i].v, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].u1, vt[i].u2, vt[i].rw, vt[i].tag);
            setctl(vt[i].rdy, vt[i].wbv, vt[i].wbrd, vt[i].fl);
            #1;
            chk($sformatf("tbl%0d_iv", i), issue_valid, vt[i].e_iv);
            chk($sformatf("tbl%0d_de", i), decode_enable, vt[i].e_de);
            chk($sformatf("tbl%0d_rd", i), issue_rd, vt[i].e_rd);
            chk($sformatf("tbl%0d_tag", i), issue_payload[7:0], vt[i].e_tag);
            chk($sformatf("tbl%0d_err", i), wb_err, vt[i].e_err);
            tick;
        end
        setin(0, 0, 0, 0, 0, 0, 0, 8'h00);
        setctl(1, 0, 0, 0);
        #1;
        chk("tbl_stall_total", stall_cycles, 32'd3);

        // RAW on rd=5 resolved by writeback
        do_reset;
        setin(1, 0, 0, 5, 0, 0, 1, 8'h11); setctl(1, 0, 0, 0);
        #1; tick;
        setin(1, 5, 0, 0, 1, 0, 0, 8'h22);
        #1; chk("raw_prod_fire", issue_valid, 1'b1); tick;
        setin(0, 0, 0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("raw_wait_iv", issue_valid, 1'b0);
            chk("raw_wait_de", decode_enable, 1'b0);
            tick;
        end
        setctl(1, 1, 5, 0);
        #1; chk("raw_wb_cycle_iv", issue_valid, BYP); tick;
        setctl(1, 0, 0, 0);
        #1; chk("raw_after_wb_iv", issue_valid, !BYP); tick;
        #1; chk("raw_stall", stall_cycles, BYP ? 32'd3 : 32'd4);
        chk("raw_no_err", wb_err, 1'b0);

        // asynchronous reset while a bundle is held
        setin(1, 0, 0, 4, 0, 0, 1, 8'h44); setctl(0, 0, 0, 0);
        tick;
        #1; chk("mid_held_iv", issue_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_iv", issue_valid, 1'b0);
        chk("mid_rst_de", decode_enable, 1'b1);
        chk("mid_rst_stall", stall_cycles, 32'd0);

        // counter saturation on rd=7
        do_reset;
        setin(1, 0, 0, 7, 0, 0, 1, 8'h70); setctl(1, 0, 0, 0);
        #1; chk("full_c1_iv", issue_valid, 1'b0); tick;
        for (int k = 0; k < 3; k++) begin
            #1; chk("full_issue_iv", issue_valid, 1'b1); tick;
        end
        #1;
        chk("full_stall_iv", issue_valid, 1'b0);
        chk("full_stall_de", decode_enable, 1'b0);
        tick;
        setctl(1, 1, 7, 0);
        #1; chk("full_wb_iv", issue_valid, BYP); tick;
        setctl(1, 0, 0, 0);
        #1; chk("full_after_wb_iv", issue_valid, !BYP); tick;
        #1; chk("full_peak_iv", issue_valid, 1'b0); tick;

        // ready held low with no hazard
        do_reset;
        setin(1, 2, 0, 11, 1, 0, 1, 8'h5A); setctl(0, 0, 0, 0);
        #1; tick;
        setin(1, 0, 0, 13, 0, 0, 1, 8'h6B);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rdy_iv", issue_valid, 1'b1);
            chk("rdy_de", decode_enable, 1'b0);
            chk("rdy_payload", issue_payload[7:0], 8'h5A);
            tick;
        end
        setctl(1, 0, 0, 0);
        #1;
        chk("rdy_fire_iv", issue_valid, 1'b1);
        chk("rdy_fire_de", decode_enable, 1'b1);
        tick;
        setin(0, 0, 0, 0, 0, 0, 0, 8'h00);
        #1;
        chk("rdy_next_rd", issue_rd, 5'd13);
        chk("rdy_next_payload", issue_payload[7:0], 8'h6B);

        // flush during hazard wait with simultaneous writeback to rd=5
        do_reset;
        setin(1, 0, 0, 5, 0, 0, 1, 8'h31); setctl(1, 0, 0, 0);
        #1; tick;
        setin(1, 5, 0, 12, 1, 0, 1, 8'h32);
        #1; chk("fl_prod_iv", issue_valid, 1'b1); tick;
        setin(0, 0, 0, 0, 0, 0, 0, 8'h00);
        #1; chk("fl_haz_iv", issue_valid, 1'b0); tick;
        setctl(1, 1, 5, 1);
        #1;
        chk("fl_cycle_iv", issue_valid, 1'b0);
        chk("fl_cycle_de", decode_enable, 1'b1);
        tick;
        setctl(1, 0, 0, 0);
        #1;
        chk("fl_idle_iv", issue_valid, 1'b0);
        chk("fl_idle_de", decode_enable, 1'b1);
        chk("fl_no_err", wb_err, 1'b0);
        setin(1, 5, 0, 0, 1, 0, 0, 8'h33);
        tick;
        setin(0, 0, 0, 0, 0, 0, 0, 8'h00);
        #1; chk("fl_pend5_clear_iv", issue_valid, 1'b1); tick;
        setctl(1, 1, 12, 0);
        #1; tick;
        setctl(1, 0, 0, 0);
        #1; chk("fl_no_inc12_err", wb_err, 1'b1);
        tick; tick;
        #1; chk("err_sticky", wb_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
